// File: rtl/pipe_stage_reg.sv
// Pipeline stage register for inter-stage boundaries (ID->EXE, EXE->MEM, MEM->WB).
//
// Carries an opaque payload together with the exception vector, instruction address and
// delay-slot flag across a valid/ready boundary. With SKID_EN=1 a second (skid) entry
// absorbs one in-flight transfer, so in_ready_o is a flop and never depends
// combinationally on out_ready_i. With SKID_EN=0 the stage holds a single entry and
// in_ready_o is combinational.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush_i         drop every held entry and any input presented this cycle
//   in_valid_i      upstream entry valid
//   in_ready_o      stage can accept an entry this cycle
//   in_data_i       payload
//   in_exc_i        exception vector
//   in_pc_i         instruction address
//   in_dslot_i      entry is in a delay slot
//   next_dslot_i    accepted entry is a branch; next instruction is in its delay slot
//   out_valid_o     downstream entry valid
//   out_ready_i     downstream can accept
//   out_data_o      payload (zero when out_valid_o=0)
//   out_exc_o       exception vector (zero when out_valid_o=0)
//   out_pc_o        instruction address (zero when out_valid_o=0)
//   out_dslot_o     delay-slot flag (zero when out_valid_o=0)
//   is_in_dslot_o   delay-slot state returned to ID
//   count_o         entries held (0..2, at most 1 when SKID_EN=0)

module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned EXC_W   = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [EXC_W-1:0]  in_exc_i,
  input  logic [ADDR_W-1:0] in_pc_i,
  input  logic              in_dslot_i,
  input  logic              next_dslot_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [EXC_W-1:0]  out_exc_o,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic              out_dslot_o,
  output logic              is_in_dslot_o,
  output logic [1:0]        count_o
);

  typedef struct packed {
    logic              dslot;
    logic [ADDR_W-1:0] pc;
    logic [EXC_W-1:0]  exc;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  entry_t     in_ent;
  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       dslot_q, dslot_d;
  logic       ready_q, ready_d;
  logic       accept, emit;
  logic [1:0] count_d;

  assign in_ent = '{dslot: in_dslot_i, pc: in_pc_i, exc: in_exc_i, data: in_data_i};

  // Skid variant: ready is a flop tracking "not full"; single variant: pass-through ready.
  assign in_ready_o = SKID_EN ? ready_q : (!main_valid_q || out_ready_i);

  assign accept = in_valid_i && in_ready_o;
  assign emit   = main_valid_q && out_ready_i;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    dslot_d      = dslot_q;

    if (flush_i) begin
      main_d       = '0;
      main_valid_d = 1'b0;
      skid_d       = '0;
      skid_valid_d = 1'b0;
      dslot_d      = 1'b0;
    end else begin
      if (accept) begin
        dslot_d = next_dslot_i;
      end

      if (emit) begin
        if (skid_valid_q) begin
          // FULL: ready is low, so no accept can coincide; skid moves up.
          main_d       = skid_q;
          skid_d       = '0;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_d = in_ent;
        end else begin
          // Drained with no refill: zero the payload so outputs stay clean.
          main_d       = '0;
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        if (!main_valid_q) begin
          main_d       = in_ent;
          main_valid_d = 1'b1;
        end else if (SKID_EN) begin
          skid_d       = in_ent;
          skid_valid_d = 1'b1;
        end
      end
    end

    count_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      dslot_q      <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      dslot_q      <= dslot_d;
      ready_q      <= ready_d;
    end
  end

  assign out_valid_o   = main_valid_q;
  assign out_data_o    = main_q.data;
  assign out_exc_o     = main_q.exc;
  assign out_pc_o      = main_q.pc;
  assign out_dslot_o   = main_q.dslot;
  assign is_in_dslot_o = dslot_q;
  assign count_o       = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_dslot, next_dslot, out_ready;
  logic [127:0] in_data;
  logic [31:0]  in_exc, in_pc;

  // dut1: SKID_EN=1, dut0: SKID_EN=0; both see the same stimulus.
  logic         rdy1, ov1, ods1, isd1, rdy0, ov0, ods0, isd0;
  logic [127:0] od1, od0;
  logic [31:0]  oe1, op1, oe0, op0;
  logic [1:0]   cnt1, cnt0;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(128), .EXC_W(32), .ADDR_W(32), .SKID_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_data_i(in_data), .in_exc_i(in_exc), .in_pc_i(in_pc), .in_dslot_i(in_dslot),
    .next_dslot_i(next_dslot), .out_valid_o(ov1), .out_ready_i(out_ready),
    .out_data_o(od1), .out_exc_o(oe1), .out_pc_o(op1), .out_dslot_o(ods1),
    .is_in_dslot_o(isd1), .count_o(cnt1)
  );

  pipe_stage_reg #(.DATA_W(128), .EXC_W(32), .ADDR_W(32), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .in_data_i(in_data), .in_exc_i(in_exc), .in_pc_i(in_pc), .in_dslot_i(in_dslot),
    .next_dslot_i(next_dslot), .out_valid_o(ov0), .out_ready_i(out_ready),
    .out_data_o(od0), .out_exc_o(oe0), .out_pc_o(op0), .out_dslot_o(ods0),
    .is_in_dslot_o(isd0), .count_o(cnt0)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: FIFO of entries per instance ----------------
  typedef struct packed {
    logic         dslot;
    logic [31:0]  pc;
    logic [31:0]  exc;
    logic [127:0] data;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  bit   ds0 = 1'b0, ds1 = 1'b0;

  always @(posedge clk) begin
    bit   r0, r1;
    ent_t e;
    r0 = (q0.size() == 0) || out_ready;
    r1 = (q1.size() < 2);
    e  = '{dslot: in_dslot, pc: in_pc, exc: in_exc, data: in_data};
    if (rst) started = 1'b1;
    if (rst || flush) begin
      q0.delete(); q1.delete();
      ds0 = 1'b0;  ds1 = 1'b0;
    end else begin
      if (q0.size() > 0 && out_ready) void'(q0.pop_front());
      if (in_valid && r0) begin q0.push_back(e); ds0 = next_dslot; end
      if (q1.size() > 0 && out_ready) void'(q1.pop_front());
      if (in_valid && r1) begin q1.push_back(e); ds1 = next_dslot; end
    end
  end

  // Compare both instances against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    ent_t h0, h1;
    if (started) begin
      h0 = (q0.size() > 0) ? q0[0] : '0;
      h1 = (q1.size() > 0) ? q1[0] : '0;
      chk("s1.out_valid", {127'b0, ov1}, {127'b0, q1.size() > 0});
      chk("s1.in_ready", {127'b0, rdy1}, {127'b0, q1.size() < 2});
      chk("s1.count", {126'b0, cnt1}, 128'(q1.size()));
      chk("s1.is_in_dslot", {127'b0, isd1}, {127'b0, ds1});
      chk("s1.out_pc", {96'b0, op1}, {96'b0, h1.pc});
      chk("s1.out_exc", {96'b0, oe1}, {96'b0, h1.exc});
      chk("s1.out_data", od1, h1.data);
      chk("s1.out_dslot", {127'b0, ods1}, {127'b0, h1.dslot});
      chk("s0.out_valid", {127'b0, ov0}, {127'b0, q0.size() > 0});
      chk("s0.in_ready", {127'b0, rdy0}, {127'b0, (q0.size() == 0) || out_ready});
      chk("s0.count", {126'b0, cnt0}, 128'(q0.size()));
      chk("s0.is_in_dslot", {127'b0, isd0}, {127'b0, ds0});
      chk("s0.out_pc", {96'b0, op0}, {96'b0, h0.pc});
      chk("s0.out_exc", {96'b0, oe0}, {96'b0, h0.exc});
      chk("s0.out_data", od0, h0.data);
      chk("s0.out_dslot", {127'b0, ods0}, {127'b0, h0.dslot});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [31:0] pc, input bit nd, input bit ordy,
                       input bit fl, input bit rs);
    in_valid   = v;
    in_pc      = pc;
    in_data    = {pc, ~pc, pc ^ 32'h5a5a_0000, 32'hc0de_0000 | pc};
    in_exc     = pc ^ 32'h0000_ff00;
    in_dslot   = pc[2];
    next_dslot = nd;
    out_ready  = ordy;
    flush      = fl;
    rst        = rs;
  endtask

  task automatic cyc(input bit v, input logic [31:0] pc, input bit nd, input bit ordy,
                     input bit fl, input bit rs);
    drive(v, pc, nd, ordy, fl, rs);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("reset.count", {126'b0, cnt1}, 128'd0);
    chk("reset.out_valid", {127'b0, ov1}, 128'd0);
    chk("reset.in_ready", {127'b0, rdy1}, 128'd1);
    chk("reset.out_pc", {96'b0, op1}, 128'd0);

    // Stream
    cyc(1, 32'h100, 0, 1, 0, 0);
    chk("stream.pc0", {96'b0, op1}, 128'h100);
    chk("stream.count", {126'b0, cnt1}, 128'd1);
    cyc(1, 32'h104, 0, 1, 0, 0);
    chk("stream.pc1", {96'b0, op1}, 128'h104);
    cyc(1, 32'h108, 0, 1, 0, 0);
    chk("stream.pc2", {96'b0, op1}, 128'h108);
    chk("stream.in_ready", {127'b0, rdy1}, 128'd1);
    chk("stream.exc", {96'b0, oe1}, 128'h0000_fe08);
    cyc(0, 0, 0, 1, 0, 0);
    chk("stream.drained_pc", {96'b0, op1}, 128'd0);

    // Backpressure
    cyc(1, 32'h200, 0, 0, 0, 0);
    cyc(1, 32'h204, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("bp.count", {126'b0, cnt1}, 128'd2);
    chk("bp.in_ready", {127'b0, rdy1}, 128'd0);
    chk("bp.hold_pc", {96'b0, op1}, 128'h200);
    cyc(0, 0, 0, 1, 0, 0);
    chk("bp.pc_second", {96'b0, op1}, 128'h204);
    chk("bp.count1", {126'b0, cnt1}, 128'd1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("bp.count0", {126'b0, cnt1}, 128'd0);
    chk("bp.pc_zero", {96'b0, op1}, 128'd0);

    // Flush while full, with a live input presented
    cyc(1, 32'h280, 0, 0, 0, 0);
    cyc(1, 32'h284, 1, 0, 0, 0);
    chk("flush.pre_dslot", {127'b0, isd1}, 128'd1);
    cyc(1, 32'h300, 1, 0, 1, 0);
    chk("flush.out_valid", {127'b0, ov1}, 128'd0);
    chk("flush.count", {126'b0, cnt1}, 128'd0);
    chk("flush.is_in_dslot", {127'b0, isd1}, 128'd0);
    chk("flush.out_data", od1, 128'd0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("flush.no_300", {127'b0, ov1}, 128'd0);

    // Delay slot tracking
    cyc(1, 32'h400, 1, 1, 0, 0);
    chk("dslot.set", {127'b0, isd1}, 128'd1);
    cyc(1, 32'h404, 0, 1, 0, 0);
    chk("dslot.clear", {127'b0, isd1}, 128'd0);
    chk("dslot.out_dslot", {127'b0, ods1}, 128'd1);
    cyc(1, 32'h408, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("dslot.hold", {127'b0, isd1}, 128'd1);

    // Reset mid-operation with flush and valid also asserted
    cyc(1, 32'h500, 0, 0, 0, 0);
    cyc(1, 32'h504, 0, 0, 0, 0);
    chk("rstmid.pre_count", {126'b0, cnt1}, 128'd2);
    cyc(1, 32'h508, 1, 0, 1, 1);
    chk("rstmid.count", {126'b0, cnt1}, 128'd0);
    chk("rstmid.in_ready", {127'b0, rdy1}, 128'd1);
    chk("rstmid.is_in_dslot", {127'b0, isd1}, 128'd0);
    chk("rstmid.out_pc", {96'b0, op1}, 128'd0);

    // Single-entry variant: combinational ready
    cyc(1, 32'h600, 0, 0, 0, 0);
    drive(1, 32'h604, 0, 0, 0, 0);
    #1;
    chk("s0.stall_ready", {127'b0, rdy0}, 128'd0);
    chk("s0.stall_pc", {96'b0, op0}, 128'h600);
    drive(1, 32'h604, 0, 1, 0, 0);
    #1;
    chk("s0.pass_ready", {127'b0, rdy0}, 128'd1);
    @(posedge clk);
    #1;
    chk("s0.replace_pc", {96'b0, op0}, 128'h604);
    chk("s0.count", {126'b0, cnt0}, 128'd1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("s0.drained", {127'b0, ov0}, 128'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for inter-stage boundaries (ID->EXE, EXE->MEM, MEM->WB). Successor to the fixed-field stall/flush stage registers.
- Carries an opaque payload bus plus exception vector, instruction address and delay-slot flag.
- Uses a valid/ready handshake with an optional 2-entry skid buffer, so upstream ready never depends combinationally on downstream ready.
- Tracks the "next instruction is in delay slot" state returned to ID.

Parameters:
DATA_W, 128, width of opaque control/operand payload (alu_sel, alu_op, reg1, reg2, wreg, wd, hi/lo flags packed by the stage)
EXC_W, 32, width of exception vector
ADDR_W, 32, width of instruction address
SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
flush_i  input  1  discard all held entries (exception/eret)
in_valid_i  input  1  upstream entry valid
in_ready_o  output  1  stage can accept an entry this cycle
in_data_i  input  DATA_W  payload
in_exc_i  input  EXC_W  exception vector
in_pc_i  input  ADDR_W  current instruction address
in_dslot_i  input  1  entry is in a delay slot
next_dslot_i  input  1  accepted entry is a branch; the next instruction is in its delay slot
out_valid_o  output  1  downstream entry valid
out_ready_i  input  1  downstream can accept
out_data_o  output  DATA_W  payload
out_exc_o  output  EXC_W  exception vector
out_pc_o  output  ADDR_W  instruction address
out_dslot_o  output  1  delay-slot flag
is_in_dslot_o  output  1  registered delay-slot state returned to ID
count_o  output  2  entries held (0..2; max 1 when SKID_EN=0)

Behaviour:
- Reset (rst=1 at posedge): clears out_valid_o, out_data_o, out_exc_o, out_pc_o, out_dslot_o, is_in_dslot_o, count_o and the skid entry to 0. in_ready_o=1 in the cycle after reset.
- Priority: rst > flush_i > handshake.
- Accept = in_valid_i & in_ready_o. Emit = out_valid_o & out_ready_i.
- Flush (flush_i=1 at posedge): all entries dropped and all out_* and is_in_dslot_o zeroed, count_o=0. Any input presented that cycle is discarded. The stage does not retain any entry accepted in the flush cycle.
- Payload zeroing: whenever out_valid_o=0, out_data_o, out_exc_o, out_pc_o and out_dslot_o are all 0. They are registered, so the main entry is loaded with zeros when it drains with no refill.
- Latency: an entry accepted at edge N appears on out_* after edge N (1 cycle) when the main entry is empty or emitting.
- SKID_EN=1 state machine (state = count_o):
  - EMPTY(0): accept -> ONE (load main).
  - ONE(1):
    - accept & emit -> ONE (main <= input).
    - accept & !emit -> FULL (skid <= input).
    - !accept & emit -> EMPTY (main zeroed).
    - otherwise hold.
  - FULL(2): in_ready_o=0, so no accept. Emit -> ONE (main <= skid, skid cleared). Otherwise hold.
  - in_ready_o is registered and equals (count_o != 2).
- SKID_EN=0:
  - Single entry; in_ready_o = !out_valid_o | out_ready_i (combinational).
  - Accept loads main. Emit without accept clears main.
  - FULL is unreachable; count_o is in {0,1}.
- Order is strictly preserved: skid contents always emit after main.
- Delay slot: on accept (no flush/reset), is_in_dslot_o <= next_dslot_i. Otherwise it holds its value.
- Stall is expressed solely by out_ready_i=0. Held entries are bit-stable under stall.
- No X propagation: unused skid fields are zero when empty.

Test Plan:
- Stream (SKID_EN=1): in_valid_i=1 every cycle with in_pc_i=0x100,0x104,0x108, out_ready_i=1 -> out_pc_o shows each value 1 cycle later, count_o=1, in_ready_o stays 1.
- Backpressure: fill with 0x200 and 0x204, out_ready_i=0 for 3 cycles -> count_o=2, in_ready_o=0, out_pc_o holds 0x200. Then out_ready_i=1 -> 0x200 then 0x204 emitted, count_o 2->1->0, out_pc_o=0 after drain.
- Flush in FULL while in_valid_i=1 with in_pc_i=0x300 -> next cycle out_valid_o=0, all out_* =0, count_o=0, is_in_dslot_o=0, and 0x300 never emitted.
- Delay slot: accept a branch with next_dslot_i=1 -> is_in_dslot_o=1. Accept the next entry with next_dslot_i=0 -> is_in_dslot_o=0. A cycle with no accept leaves it unchanged.
- Reset mid-operation: count_o=2, assert rst for 1 cycle together with flush_i=1 and in_valid_i=1 -> all outputs 0, in_ready_o=1 the cycle after.
- SKID_EN=0: out_ready_i=0 with entry held -> in_ready_o=0 in the same cycle. Set out_ready_i=1 with in_valid_i=1 -> in_ready_o=1 combinationally, replacement entry emitted next cycle, count_o never exceeds 1.
